// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: counter encodings, update rule, FSM states.
package branch_resolver_pkg;

  localparam int unsigned IDX_W_DEF = 5;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 32;

  // 2-bit predictor counter encodings; bit 1 is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Saturating +/-1 step of a 2-bit predictor counter
  function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_sat_event_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one event per cycle while below the saturation value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution: compares predictions with EX outcomes, drives flush/redirect,
// predictor-table write-back and misprediction statistics.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [1:0]       id_pred,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic [1:0]       upd_state,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned PC_STEP = 4;

  state_t          state;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [1:0]      ex_pred;
  logic            resolve_c;
  logic            mispred_c;

  // A branch resolves only from IDLE with the pipeline moving
  assign resolve_c = (state == IDLE) && ex_valid && !stall;
  assign mispred_c = resolve_c && (ex_pred[1] != ex_taken);

  // FSM, EX entry and registered update/flush outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_pred     <= SNT;
      flush       <= 1'b0;
      redirect_pc <= '0;
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_state   <= SNT;
    end else begin
      flush     <= 1'b0;
      upd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            ex_valid <= id_valid & id_is_branch;
            ex_pc    <= id_pc;
            ex_pred  <= id_pred;
          end
          if (resolve_c) begin
            upd_valid <= 1'b1;
            upd_idx   <= ex_pc[IDX_W+1:2];
            upd_state <= next_cnt(ex_pred, ex_taken);
          end
          if (mispred_c) begin
            flush       <= 1'b1;
            redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(PC_STEP);
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          // Wrong-path EX entry is dropped and ID is ignored, even under stall
          ex_valid <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          ex_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  sat_event_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (resolve_c),
    .count   (branch_cnt)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (mispred_c),
    .count   (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_branch_resolver;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             stall;
  logic             id_valid;
  logic             id_is_branch;
  logic [XLEN-1:0]  id_pc;
  logic [1:0]       id_pred;
  logic             ex_taken;
  logic [XLEN-1:0]  ex_target;

  logic             flush,      flush4;
  logic [XLEN-1:0]  redirect_pc, redirect_pc4;
  logic             upd_valid,  upd_valid4;
  logic [IDX_W-1:0] upd_idx,    upd_idx4;
  logic [1:0]       upd_state,  upd_state4;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  logic [3:0]       branch_cnt4, mispred_cnt4;

  always #5 clk = ~clk;

  branch_resolver #(.IDX_W(IDX_W), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .id_valid(id_valid),
    .id_is_branch(id_is_branch), .id_pc(id_pc), .id_pred(id_pred),
    .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_state(upd_state), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolver #(.IDX_W(IDX_W), .XLEN(XLEN), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .id_valid(id_valid),
    .id_is_branch(id_is_branch), .id_pc(id_pc), .id_pred(id_pred),
    .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush4),
    .redirect_pc(redirect_pc4), .upd_valid(upd_valid4), .upd_idx(upd_idx4),
    .upd_state(upd_state4), .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
  );

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

  // Behavioural model: the branch sitting in EX, whether a flush cycle is in progress,
  // and the outputs expected after the most recent edge.
  logic             m_ex_v;
  logic [31:0]      m_ex_pc;
  int unsigned      m_ex_pred;
  logic             m_flushing;
  logic             e_flush, e_upd_valid;
  logic [31:0]      e_idx, e_state, e_redir;
  int unsigned      e_b, e_m, e_b4, e_m4;

  function automatic int unsigned bump(input int unsigned v, input int unsigned cap);
    return (v < cap) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_ex_v = 1'b0; m_ex_pc = '0; m_ex_pred = 0; m_flushing = 1'b0;
    e_flush = 1'b0; e_upd_valid = 1'b0; e_idx = '0; e_state = '0; e_redir = '0;
    e_b = 0; e_m = 0; e_b4 = 0; e_m4 = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs the DUT sampled, then compare
  task automatic step();
    bit resolve, mis, pred_taken;
    @(posedge clk);
    pred_taken = (m_ex_pred >= 2);
    resolve = !m_flushing && m_ex_v && !stall;
    mis = resolve && (pred_taken != ex_taken);
    e_upd_valid = resolve;
    e_flush = mis;
    if (resolve) begin
      e_idx = (m_ex_pc / 4) % 32;
      if (ex_taken) e_state = 32'((m_ex_pred == 3) ? 3 : m_ex_pred + 1);
      else          e_state = 32'((m_ex_pred == 0) ? 0 : m_ex_pred - 1);
      e_b  = bump(e_b, 32'hFFFF_FFFF);
      e_b4 = bump(e_b4, 15);
    end
    if (mis) begin
      e_redir = ex_taken ? ex_target : m_ex_pc + 32'd4;
      e_m  = bump(e_m, 32'hFFFF_FFFF);
      e_m4 = bump(e_m4, 15);
    end
    if (m_flushing) begin
      m_ex_v = 1'b0;
    end else if (!stall) begin
      m_ex_v    = id_valid && id_is_branch;
      m_ex_pc   = id_pc;
      m_ex_pred = 32'(id_pred);
    end
    m_flushing = mis;
    #1;
    chk("flush", 32'(flush), 32'(e_flush));
    chk("upd_valid", 32'(upd_valid), 32'(e_upd_valid));
    chk("branch_cnt", branch_cnt, e_b);
    chk("mispred_cnt", mispred_cnt, e_m);
    chk("branch_cnt4", 32'(branch_cnt4), e_b4);
    chk("mispred_cnt4", 32'(mispred_cnt4), e_m4);
    if (e_upd_valid) begin
      chk("upd_idx", 32'(upd_idx), e_idx);
      chk("upd_state", 32'(upd_state), e_state);
    end
    if (e_flush) chk("redirect_pc", redirect_pc, e_redir);
  endtask

  task automatic drive(input logic st, input logic iv, input logic ib, input logic [31:0] pc,
                       input logic [1:0] pr, input logic tk, input logic [31:0] tg);
    stall = st; id_valid = iv; id_is_branch = ib; id_pc = pc; id_pred = pr;
    ex_taken = tk; ex_target = tg;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 1'b0; id_valid = 1'b0; id_is_branch = 1'b0; id_pc = '0; id_pred = '0;
    ex_taken = 1'b0; ex_target = '0;
    model_reset();
    #1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // Correct prediction, strong taken
    drive(0, 1, 1, 32'h40, 2'b11, 0, 32'h0);
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h0);
    chk("cp_upd_valid", 32'(upd_valid), 32'd1);
    chk("cp_upd_idx", 32'(upd_idx), 32'h10);
    chk("cp_upd_state", 32'(upd_state), 32'd3);
    chk("cp_flush", 32'(flush), 32'd0);
    chk("cp_branch_cnt", branch_cnt, 32'd1);

    // Mispredict: predicted taken, actually not taken; wrong-path branch behind it
    drive(0, 1, 1, 32'h100, 2'b10, 0, 32'h0);
    drive(0, 1, 1, 32'h200, 2'b11, 0, 32'h900);
    chk("mnt_flush", 32'(flush), 32'd1);
    chk("mnt_redirect", redirect_pc, 32'h104);
    chk("mnt_upd_state", 32'(upd_state), 32'd1);
    chk("mnt_mispred_cnt", mispred_cnt, 32'd1);
    drive(0, 1, 1, 32'h300, 2'b11, 1, 32'h500);
    chk("mnt_no_upd_in_flush", 32'(upd_valid), 32'd0);
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h0);
    chk("mnt_no_upd_after", 32'(upd_valid), 32'd0);

    // Mispredict: predicted not taken, actually taken
    drive(0, 1, 1, 32'h400, 2'b01, 0, 32'h0);
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h2000);
    chk("mt_redirect", redirect_pc, 32'h2000);
    chk("mt_upd_state", 32'(upd_state), 32'd2);
    drive(0, 0, 0, 32'h0, 2'b00, 0, 32'h0);

    // Strong not-taken confirmed stays at 00
    drive(0, 1, 1, 32'h404, 2'b00, 0, 32'h0);
    drive(0, 0, 0, 32'h0, 2'b00, 0, 32'h0);
    chk("sat_upd_valid", 32'(upd_valid), 32'd1);
    chk("sat_upd_state", 32'(upd_state), 32'd0);

    // Stall hold: three stalled cycles, then a single resolution
    drive(0, 1, 1, 32'h80, 2'b11, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h0, 2'b00, 1, 32'h10);
      chk("stall_no_upd", 32'(upd_valid), 32'd0);
    end
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h10);
    chk("stall_upd", 32'(upd_valid), 32'd1);
    chk("stall_idx", 32'(upd_idx), 32'h0);
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h10);
    chk("stall_single_pulse", 32'(upd_valid), 32'd0);

    // Reset asserted during a flush cycle
    drive(0, 1, 1, 32'h100, 2'b10, 0, 32'h0);
    drive(0, 0, 0, 32'h0, 2'b00, 0, 32'h0);
    chk("rmf_flush_before", 32'(flush), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rmf_flush", 32'(flush), 32'd0);
    chk("rmf_upd_valid", 32'(upd_valid), 32'd0);
    chk("rmf_branch_cnt", branch_cnt, 32'd0);
    chk("rmf_mispred_cnt", mispred_cnt, 32'd0);
    #2 reset_n = 1'b1;
    drive(0, 0, 0, 32'h0, 2'b00, 0, 32'h0);
    chk("rmf_idle_after", 32'(flush), 32'd0);

    // Back-to-back correct branches, 20 of them, saturating the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 32'h1000 + 32'(4 * i), 2'b11, 1, 32'h0);
      if (i > 0) chk("b2b_upd_valid", 32'(upd_valid), 32'd1);
    end
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h0);
    drive(0, 0, 0, 32'h0, 2'b00, 1, 32'h0);
    chk("b2b_branch_cnt", branch_cnt, 32'd20);
    chk("cnt4_saturated", 32'(branch_cnt4), 32'hF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, 1'($urandom), ($urandom % 4) != 0,
            $urandom & 32'hFFFF_FFFC, 2'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
